// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and the memory arbiter state encoding.
package lc3b_types;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_A_BUSY,
        ARB_B_BUSY
    } mem_arb_state_t;

endpackage

// File: rtl/arb_port_hold.sv
// Per-port completion flag and read-data hold register; the flag is held
// until the pipeline advances so the datapath sees a stable response.
module arb_port_hold
    import lc3b_types::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              complete,
    input  logic              is_read,
    input  logic [DATA_W-1:0] rdata,
    input  logic              advance,
    output logic              resp,
    output logic [DATA_W-1:0] rdata_q
);

    logic done_q;

    // A completion on the same edge as advance wins: that response belongs
    // to the next pipeline step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (complete) begin
                done_q <= 1'b1;
            end else if (advance) begin
                done_q <= 1'b0;
            end
            if (complete && is_read) begin
                rdata_q <= rdata;
            end
        end
    end

    assign resp = done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Merges the instruction port (A, read-only) and data port (B, read/write)
// onto a single physical memory port with fixed B priority.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = WORD_W,
    parameter int DATA_W = WORD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic                a_read,
    input  logic [ADDR_W-1:0]   a_address,
    output logic                a_resp,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W/8-1:0] b_wmask,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_resp,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [DATA_W/8-1:0] pmem_wmask,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    mem_arb_state_t state_q, state_d;

    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W/8-1:0] req_wmask;
    logic [DATA_W-1:0]   req_wdata;

    logic pend_a, pend_b;
    logic complete_a, complete_b;

    // done flags block reissue, so A cannot be starved by a persistent B
    assign pend_a = a_read & ~a_resp;
    assign pend_b = (b_read | b_write) & ~b_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pend_b) begin
                    state_d = ARB_B_BUSY;
                end else if (pend_a) begin
                    state_d = ARB_A_BUSY;
                end
            end
            ARB_A_BUSY, ARB_B_BUSY: begin
                if (pmem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        unique case (state_q)
            ARB_A_BUSY: pmem_read = 1'b1;
            ARB_B_BUSY: begin
                pmem_read  = ~req_write;
                pmem_write = req_write;
            end
            default: ;
        endcase
    end

    // Request registers are loaded only on the grant edge so pmem_* stays
    // stable however the ports change while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (pend_b) begin
                req_write <= b_write;
                req_addr  <= b_address;
                req_wmask <= b_wmask;
                req_wdata <= b_wdata;
            end else if (pend_a) begin
                req_write <= 1'b0;
                req_addr  <= a_address;
                req_wmask <= '0;
                req_wdata <= '0;
            end
        end
    end

    assign pmem_address = req_addr;
    assign pmem_wmask   = req_wmask;
    assign pmem_wdata   = req_wdata;

    // A port that dropped its request mid-access gets no completion.
    assign complete_a = (state_q == ARB_A_BUSY) & pmem_resp & a_read;
    assign complete_b = (state_q == ARB_B_BUSY) & pmem_resp & (b_read | b_write);

    arb_port_hold #(.DATA_W(DATA_W)) u_hold_a (
        .clk      (clk),
        .rst      (rst),
        .complete (complete_a),
        .is_read  (1'b1),
        .rdata    (pmem_rdata),
        .advance  (advance),
        .resp     (a_resp),
        .rdata_q  (a_rdata)
    );

    arb_port_hold #(.DATA_W(DATA_W)) u_hold_b (
        .clk      (clk),
        .rst      (rst),
        .complete (complete_b),
        .is_read  (~req_write),
        .rdata    (pmem_rdata),
        .advance  (advance),
        .resp     (b_resp),
        .rdata_q  (b_rdata)
    );

endmodule
